axi4_mst_fsm: RTL and testbench
===============================

AXI4_MST_FSM -- requirements
Module: axi4_mst_fsm

Interface
REQ-001 The block SHALL have parameter MST_ID, default 0, giving the value driven on awid/arid.
REQ-002 The block SHALL have parameter MAX_OUTSTANDING, default 1, fixed at 1: one transaction in flight.
REQ-003 The block SHALL have port aclk, input, 1 bit: the single clock.
REQ-004 The block SHALL have port areset, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have AW channel outputs awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awregion, awuser and awvalid, plus input awready, all at AXI4 define widths.
REQ-006 The block SHALL have W channel outputs wdata, wstrb, wlast, wuser and wvalid, plus input wready.
REQ-007 The block SHALL have B channel inputs bid, bresp, buser and bvalid, plus output bready.
REQ-008 The block SHALL have AR channel outputs matching AW with the ar prefix, plus input arready.
REQ-009 The block SHALL have R channel inputs rid, rdata, rresp, rlast, ruser and rvalid, plus output rready.
REQ-010 The user request port SHALL be: usr_req_i in, 1; usr_req_ready_o out, 1; usr_wen_i in, 1 (1 = write); usr_addr_i in, AXI4_ADDR_WIDTH; usr_len_i in, 8 (beats-1).
REQ-011 The user write-data port SHALL be: usr_wdat_i in, AXI4_DATA_WIDTH; usr_wstrb_i in, AXI4_WSTRB_WIDTH; usr_wvalid_i in, 1; usr_wready_o out, 1.
REQ-012 The user read-data port SHALL be: usr_rdat_o out, AXI4_DATA_WIDTH; usr_rvalid_o out, 1; usr_rlast_o out, 1.
REQ-013 The user completion port SHALL be: usr_done_o out, 1 (one-cycle pulse); usr_resp_o out, 2.

Function
REQ-014 The FSM SHALL have states IDLE, RD_ADDR, RD_DATA, WR_ADDR, WR_DATA and WR_RESP.
REQ-015 usr_req_ready_o SHALL equal (state==IDLE); a request is accepted when usr_req_i && usr_req_ready_o.
REQ-016 On acceptance, addr, len, wen and id SHALL be registered, and the FSM SHALL move to RD_ADDR (wen=0) or WR_ADDR (wen=1) on the next cycle.
REQ-017 Constant fields SHALL be: size=AXI4_DATA_BLOG, burst=INCR (2'b01), lock=0, cache=4'b0010, prot/qos/region/user=0.
REQ-018 The addr/len registers SHALL hold stable while a valid is high, and a valid SHALL not drop before its ready.
REQ-019 If (addr[11:0] + ((len+1) << AXI4_DATA_BLOG)) exceeds 4096, the request SHALL cause no AXI traffic: it stays in IDLE and pulses usr_done_o the next cycle with usr_resp_o=2'b10.
REQ-020 In RD_ADDR, arvalid SHALL be 1, and arvalid && arready SHALL move to RD_DATA with the beat counter cleared.
REQ-021 In RD_DATA, rready SHALL be 1.
REQ-022 In RD_DATA, each rvalid beat SHALL drive usr_rvalid_o=1 in the same cycle, with usr_rdat_o=rdata and usr_rlast_o=rlast, and SHALL increment the 8-bit counter.
REQ-023 The worst rresp SHALL accumulate: the numerically larger of the stored and incoming value is kept.
REQ-024 A read SHALL terminate on the beat with rlast, returning to IDLE and pulsing usr_done_o.
REQ-025 If rlast arrives when counter != len, usr_resp_o SHALL be 2'b10 regardless of rresp.
REQ-026 Beats with rid != MST_ID SHALL still be consumed but SHALL force usr_resp_o=2'b10.
REQ-027 In WR_ADDR, awvalid SHALL be 1, and the handshake SHALL move to WR_DATA with the counter cleared; W SHALL never precede the AW handshake.
REQ-028 In WR_DATA, the W channel SHALL pass through the user port: wvalid=usr_wvalid_i, usr_wready_o=wready, wdata=usr_wdat_i, wstrb=usr_wstrb_i.
REQ-029 In WR_DATA, wlast SHALL equal (counter==len).
REQ-030 Each W handshake SHALL increment the counter, and the handshake with wlast=1 SHALL move to WR_RESP.
REQ-031 Outside WR_DATA, usr_wready_o and wvalid SHALL be 0.
REQ-032 In WR_RESP, bready SHALL be 1.
REQ-033 In WR_RESP, bvalid SHALL return to IDLE with usr_done_o=1 and usr_resp_o=bresp, or 2'b10 if bid != MST_ID.
REQ-034 usr_resp_o SHALL hold its value until the next usr_done_o.
REQ-035 usr_done_o and usr_req_ready_o MAY both be 1 in the done cycle, and a new request accepted then SHALL be honoured.

Reset
REQ-036 While areset=1 at a rising aclk edge, the FSM SHALL go to IDLE.
REQ-037 On that edge, all valids, ready outputs, usr_done_o, usr_rvalid_o and the counter SHALL be 0, and usr_resp_o and all registered fields SHALL be cleared to 0.
REQ-038 Reset mid-transaction SHALL abandon the burst immediately, with no usr_done_o.
REQ-039 After reset is released, usr_req_ready_o SHALL be 1 in the first cycle.

Verification
REQ-040 Read 0x1000, len=3, slave returns 4 beats OKAY with rlast on the 4th -> araddr=0x1000, arlen=3, arsize=AXI4_DATA_BLOG, four usr_rvalid_o pulses, usr_done_o one cycle after beat 4 with resp 0.
REQ-041 Write 0x2000, len=1, wready toggling 1,0,1 -> exactly 2 W handshakes, wlast only on the second, bresp=2'b00 -> usr_done_o with resp 0.
REQ-042 Request addr=0x0FF0, len=3 with 64-bit data (0x0FF0+32 > 0x1000) -> no awvalid/arvalid, usr_done_o next cycle, resp 2'b10.
REQ-043 Read len=3 with rlast on the 2nd beat -> FSM back to IDLE, resp 2'b10; and separately, one beat rresp=2'b10 among OKAY beats -> resp 2'b10.
REQ-044 areset asserted during WR_DATA after 1 of 4 beats -> next cycle all valids 0 and FSM in IDLE; a fresh read then completes normally.
REQ-045 arready held 0 for 5 cycles -> arvalid and araddr stable for all 5 cycles, and the transaction completes once arready rises.

Source files
------------

// File: rtl/axi4_mst_fsm.sv
// axi4_mst_fsm
//   Single-outstanding AXI4 master. It turns one user request (read or
//   write burst) into AXI4 AR/R or AW/W/B traffic.
//   - The W channel passes straight through from the user write-data port.
//   - R beats pass straight through to the user read-data port.
//   - Completion is reported as a one-cycle usr_done_o pulse. usr_resp_o
//     carries the response and holds it until the next completion.
//   - A burst that would cross a 4 KiB page is refused without any bus
//     activity and completes with SLVERR.
// Ports
//   aclk, areset         : clock and synchronous active-high reset
//   aw*/w*/b*/ar*/r*     : AXI4 master channels
//   usr_req_*            : request handshake (wen, addr, len = beats-1)
//   usr_w*               : write data in (valid/ready)
//   usr_r*               : read data out (valid, data, last)
//   usr_done_o/usr_resp_o: completion pulse and response
module axi4_mst_fsm #(
  parameter int MST_ID           = 0,
  parameter int MAX_OUTSTANDING  = 1,
  parameter int AXI4_ID_WIDTH    = 4,
  parameter int AXI4_ADDR_WIDTH  = 32,
  parameter int AXI4_DATA_WIDTH  = 64,
  parameter int AXI4_USER_WIDTH  = 1,
  parameter int AXI4_WSTRB_WIDTH = AXI4_DATA_WIDTH / 8,
  parameter int AXI4_DATA_BLOG   = $clog2(AXI4_DATA_WIDTH / 8)
) (
  input  logic                        aclk,
  input  logic                        areset,
  // AW channel
  output logic [AXI4_ID_WIDTH-1:0]    awid,
  output logic [AXI4_ADDR_WIDTH-1:0]  awaddr,
  output logic [7:0]                  awlen,
  output logic [2:0]                  awsize,
  output logic [1:0]                  awburst,
  output logic                        awlock,
  output logic [3:0]                  awcache,
  output logic [2:0]                  awprot,
  output logic [3:0]                  awqos,
  output logic [3:0]                  awregion,
  output logic [AXI4_USER_WIDTH-1:0]  awuser,
  output logic                        awvalid,
  input  logic                        awready,
  // W channel
  output logic [AXI4_DATA_WIDTH-1:0]  wdata,
  output logic [AXI4_WSTRB_WIDTH-1:0] wstrb,
  output logic                        wlast,
  output logic [AXI4_USER_WIDTH-1:0]  wuser,
  output logic                        wvalid,
  input  logic                        wready,
  // B channel
  input  logic [AXI4_ID_WIDTH-1:0]    bid,
  input  logic [1:0]                  bresp,
  input  logic [AXI4_USER_WIDTH-1:0]  buser,
  input  logic                        bvalid,
  output logic                        bready,
  // AR channel
  output logic [AXI4_ID_WIDTH-1:0]    arid,
  output logic [AXI4_ADDR_WIDTH-1:0]  araddr,
  output logic [7:0]                  arlen,
  output logic [2:0]                  arsize,
  output logic [1:0]                  arburst,
  output logic                        arlock,
  output logic [3:0]                  arcache,
  output logic [2:0]                  arprot,
  output logic [3:0]                  arqos,
  output logic [3:0]                  arregion,
  output logic [AXI4_USER_WIDTH-1:0]  aruser,
  output logic                        arvalid,
  input  logic                        arready,
  // R channel
  input  logic [AXI4_ID_WIDTH-1:0]    rid,
  input  logic [AXI4_DATA_WIDTH-1:0]  rdata,
  input  logic [1:0]                  rresp,
  input  logic                        rlast,
  input  logic [AXI4_USER_WIDTH-1:0]  ruser,
  input  logic                        rvalid,
  output logic                        rready,
  // User request port
  input  logic                        usr_req_i,
  output logic                        usr_req_ready_o,
  input  logic                        usr_wen_i,
  input  logic [AXI4_ADDR_WIDTH-1:0]  usr_addr_i,
  input  logic [7:0]                  usr_len_i,
  // User write-data port
  input  logic [AXI4_DATA_WIDTH-1:0]  usr_wdat_i,
  input  logic [AXI4_WSTRB_WIDTH-1:0] usr_wstrb_i,
  input  logic                        usr_wvalid_i,
  output logic                        usr_wready_o,
  // User read-data port
  output logic [AXI4_DATA_WIDTH-1:0]  usr_rdat_o,
  output logic                        usr_rvalid_o,
  output logic                        usr_rlast_o,
  // User completion port
  output logic                        usr_done_o,
  output logic [1:0]                  usr_resp_o
);

  typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_ADDR, WR_DATA, WR_RESP} state_t;

  localparam logic [1:0] RESP_SLVERR = 2'b10;

  state_t                       r_state;
  logic [AXI4_ADDR_WIDTH-1:0]   r_addr;
  logic [7:0]                   r_len;
  logic                         r_wen;
  logic [AXI4_ID_WIDTH-1:0]     r_id;
  logic [7:0]                   r_cnt;
  logic [1:0]                   r_acc;
  logic                         r_err;
  logic                         r_done;
  logic [1:0]                   r_resp;

  logic [15:0]                  w_bytes;
  logic [15:0]                  w_end;
  logic                         w_cross;
  logic                         w_rid_bad;
  logic                         w_wlast;
  logic                         w_unused;

  // Keeps the worse of two AXI responses (numerically larger wins).
  function automatic logic [1:0] worst_resp(input logic [1:0] a, input logic [1:0] b);
    return (a > b) ? a : b;
  endfunction

  // Offset within the 4 KiB page plus burst length in bytes.
  assign w_bytes   = ({8'd0, usr_len_i} + 16'd1) << AXI4_DATA_BLOG;
  assign w_end     = {4'd0, usr_addr_i[11:0]} + w_bytes;
  assign w_cross   = (w_end > 16'd4096);
  assign w_rid_bad = (rid != MST_ID[AXI4_ID_WIDTH-1:0]);
  assign w_wlast   = (r_cnt == r_len);
  assign w_unused  = ^{buser, ruser, r_wen, MAX_OUTSTANDING[0]};

  // Address channels: constant attributes, registered address/length.
  assign awid     = r_id;
  assign awaddr   = r_addr;
  assign awlen    = r_len;
  assign awsize   = AXI4_DATA_BLOG[2:0];
  assign awburst  = 2'b01;
  assign awlock   = 1'b0;
  assign awcache  = 4'b0010;
  assign awprot   = 3'd0;
  assign awqos    = 4'd0;
  assign awregion = 4'd0;
  assign awuser   = '0;
  assign awvalid  = (r_state == WR_ADDR);

  assign arid     = r_id;
  assign araddr   = r_addr;
  assign arlen    = r_len;
  assign arsize   = AXI4_DATA_BLOG[2:0];
  assign arburst  = 2'b01;
  assign arlock   = 1'b0;
  assign arcache  = 4'b0010;
  assign arprot   = 3'd0;
  assign arqos    = 4'd0;
  assign arregion = 4'd0;
  assign aruser   = '0;
  assign arvalid  = (r_state == RD_ADDR);

  // W passes through only while a write burst is in its data phase.
  assign wdata        = usr_wdat_i;
  assign wstrb        = usr_wstrb_i;
  assign wuser        = '0;
  assign wvalid       = (r_state == WR_DATA) && usr_wvalid_i;
  assign wlast        = (r_state == WR_DATA) && w_wlast;
  assign usr_wready_o = (r_state == WR_DATA) && wready;

  assign bready = (r_state == WR_RESP);
  assign rready = (r_state == RD_DATA);

  assign usr_rdat_o      = rdata;
  assign usr_rvalid_o    = rready && rvalid;
  assign usr_rlast_o     = rready && rlast;
  assign usr_req_ready_o = (r_state == IDLE);
  assign usr_done_o      = r_done;
  assign usr_resp_o      = r_resp;

  always_ff @(posedge aclk) begin
    if (areset) begin
      r_state <= IDLE;
      r_addr  <= '0;
      r_len   <= '0;
      r_wen   <= 1'b0;
      r_id    <= '0;
      r_cnt   <= '0;
      r_acc   <= '0;
      r_err   <= 1'b0;
      r_done  <= 1'b0;
      r_resp  <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (usr_req_i) begin
            if (w_cross) begin
              // Page-crossing burst is refused; no bus traffic at all.
              r_done <= 1'b1;
              r_resp <= RESP_SLVERR;
            end else begin
              r_addr  <= usr_addr_i;
              r_len   <= usr_len_i;
              r_wen   <= usr_wen_i;
              r_id    <= MST_ID[AXI4_ID_WIDTH-1:0];
              r_acc   <= '0;
              r_err   <= 1'b0;
              r_state <= usr_wen_i ? WR_ADDR : RD_ADDR;
            end
          end
        end
        RD_ADDR: begin
          if (arready) begin
            r_cnt   <= '0;
            r_state <= RD_DATA;
          end
        end
        RD_DATA: begin
          if (rvalid) begin
            r_cnt <= r_cnt + 8'd1;
            r_acc <= worst_resp(r_acc, rresp);
            if (w_rid_bad) r_err <= 1'b1;
            if (rlast) begin
              // Foreign ID on any beat or a short/long burst overrides rresp.
              r_done  <= 1'b1;
              r_resp  <= (r_err || w_rid_bad || (r_cnt != r_len)) ? RESP_SLVERR
                                                                  : worst_resp(r_acc, rresp);
              r_state <= IDLE;
            end
          end
        end
        WR_ADDR: begin
          if (awready) begin
            r_cnt   <= '0;
            r_state <= WR_DATA;
          end
        end
        WR_DATA: begin
          if (usr_wvalid_i && wready) begin
            r_cnt <= r_cnt + 8'd1;
            if (w_wlast) r_state <= WR_RESP;
          end
        end
        WR_RESP: begin
          if (bvalid) begin
            r_done  <= 1'b1;
            r_resp  <= (bid != MST_ID[AXI4_ID_WIDTH-1:0]) ? RESP_SLVERR : bresp;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi4_mst_fsm.sv
// tb_axi4_mst_fsm: bench for axi4_mst_fsm. Stimulus tasks act as user and
// AXI slave and push expected AR/AW/W/R/done items into queues; a separate
// monitor pops and compares them whenever the DUT shows the matching event.
module tb_axi4_mst_fsm;
  localparam int MST_ID = 5;
  localparam int IDW = 4, AW = 32, DW = 64, UW = 1, SW = 8;

  logic aclk = 1'b0;
  always #5 aclk = ~aclk;

  logic areset;
  logic [IDW-1:0] awid, arid, bid, rid;
  logic [AW-1:0] awaddr, araddr;
  logic [7:0] awlen, arlen;
  logic [2:0] awsize, arsize, awprot, arprot;
  logic [1:0] awburst, arburst, bresp, rresp;
  logic awlock, arlock, awvalid, arvalid, awready, arready;
  logic [3:0] awcache, arcache, awqos, arqos, awregion, arregion;
  logic [UW-1:0] awuser, aruser, wuser, buser, ruser;
  logic [DW-1:0] wdata, rdata;
  logic [SW-1:0] wstrb;
  logic wlast, wvalid, wready, bvalid, bready, rlast, rvalid, rready;
  logic usr_req_i, usr_req_ready_o, usr_wen_i;
  logic [AW-1:0] usr_addr_i;
  logic [7:0] usr_len_i;
  logic [DW-1:0] usr_wdat_i, usr_rdat_o;
  logic [SW-1:0] usr_wstrb_i;
  logic usr_wvalid_i, usr_wready_o, usr_rvalid_o, usr_rlast_o, usr_done_o;
  logic [1:0] usr_resp_o;

  axi4_mst_fsm #(.MST_ID(MST_ID)) dut (
    .aclk(aclk), .areset(areset),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awlock(awlock), .awcache(awcache), .awprot(awprot), .awqos(awqos),
    .awregion(awregion), .awuser(awuser), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wuser(wuser), .wvalid(wvalid),
    .wready(wready),
    .bid(bid), .bresp(bresp), .buser(buser), .bvalid(bvalid), .bready(bready),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arqos(arqos),
    .arregion(arregion), .aruser(aruser), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .ruser(ruser),
    .rvalid(rvalid), .rready(rready),
    .usr_req_i(usr_req_i), .usr_req_ready_o(usr_req_ready_o), .usr_wen_i(usr_wen_i),
    .usr_addr_i(usr_addr_i), .usr_len_i(usr_len_i),
    .usr_wdat_i(usr_wdat_i), .usr_wstrb_i(usr_wstrb_i), .usr_wvalid_i(usr_wvalid_i),
    .usr_wready_o(usr_wready_o),
    .usr_rdat_o(usr_rdat_o), .usr_rvalid_o(usr_rvalid_o), .usr_rlast_o(usr_rlast_o),
    .usr_done_o(usr_done_o), .usr_resp_o(usr_resp_o)
  );

  typedef struct packed { logic [31:0] addr; logic [7:0] len; } ax_t;
  typedef struct packed { logic [63:0] data; logic last; } rd_t;
  typedef struct packed { logic [63:0] data; logic [7:0] strb; logic last; } wr_t;

  ax_t        exp_ar[$];
  ax_t        exp_aw[$];
  rd_t        exp_rd[$];
  wr_t        exp_w[$];
  logic [1:0] exp_done[$];

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  // Reference rule: burst bytes past the page offset must fit in 4096.
  function automatic bit crosses(input logic [31:0] addr, input logic [7:0] len);
    int off;
    off = int'(addr[11:0]);
    return (off + (int'(len) + 1) * (DW / 8)) > 4096;
  endfunction

  task automatic issue_req(input bit wen, input logic [31:0] addr, input logic [7:0] len);
    for (int k = 0; k < 50 && !usr_req_ready_o; k++) tick();
    chk("req_ready", 64'(usr_req_ready_o), 64'd1);
    usr_req_i = 1'b1; usr_wen_i = wen; usr_addr_i = addr; usr_len_i = len;
    tick();
    usr_req_i = 1'b0;
  endtask

  task automatic read_txn(input logic [31:0] addr, input logic [7:0] len, input int nbeats,
                          input int ar_dly, input int bad_rid_idx, input int err_idx,
                          input logic [1:0] err_resp, input bit rnd);
    logic [63:0] ds[$];
    logic [1:0]  rs[$];
    logic [63:0] d;
    logic [1:0]  r, worst;
    bit          bad;
    if (crosses(addr, len)) begin
      exp_done.push_back(2'b10);
      issue_req(1'b0, addr, len);
      return;
    end
    worst = 2'b00;
    bad   = (nbeats != int'(len) + 1);
    for (int i = 0; i < nbeats; i++) begin
      d = {$urandom, $urandom};
      if (rnd) r = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      else     r = (i == err_idx) ? err_resp : 2'b00;
      ds.push_back(d);
      rs.push_back(r);
      if (r > worst) worst = r;
      if (i == bad_rid_idx) bad = 1'b1;
      exp_rd.push_back('{d, (i == nbeats - 1)});
    end
    exp_ar.push_back('{addr, len});
    exp_done.push_back(bad ? 2'b10 : worst);
    issue_req(1'b0, addr, len);
    for (int k = 0; k < 20 && !arvalid; k++) tick();
    chk("arvalid_up", 64'(arvalid), 64'd1);
    repeat (ar_dly) tick();
    arready = 1'b1;
    tick();
    arready = 1'b0;
    for (int i = 0; i < nbeats; i++) begin
      repeat ($urandom_range(0, 2)) tick();
      rvalid = 1'b1; rdata = ds[i]; rresp = rs[i];
      rid    = (i == bad_rid_idx) ? 4'(MST_ID + 1) : 4'(MST_ID);
      rlast  = (i == nbeats - 1);
      tick();
      rvalid = 1'b0; rlast = 1'b0;
    end
  endtask

  task automatic write_txn(input logic [31:0] addr, input logic [7:0] len, input int aw_dly,
                           input bit alt, input int b_dly, input logic [1:0] br,
                           input bit bad_bid);
    logic [63:0] ds[$];
    logic [7:0]  ss[$];
    int          c;
    bit          w;
    if (crosses(addr, len)) begin
      exp_done.push_back(2'b10);
      issue_req(1'b1, addr, len);
      return;
    end
    for (int i = 0; i <= int'(len); i++) begin
      ds.push_back({$urandom, $urandom});
      ss.push_back(8'($urandom));
      exp_w.push_back('{ds[i], ss[i], (i == int'(len))});
    end
    exp_aw.push_back('{addr, len});
    exp_done.push_back(bad_bid ? 2'b10 : br);
    issue_req(1'b1, addr, len);
    // User data and slave ready are offered early; nothing may move before AW.
    usr_wvalid_i = 1'b1; usr_wdat_i = ds[0]; usr_wstrb_i = ss[0]; wready = 1'b1;
    for (int k = 0; k < 20 && !awvalid; k++) tick();
    chk("awvalid_up", 64'(awvalid), 64'd1);
    repeat (aw_dly) tick();
    awready = 1'b1;
    tick();
    awready = 1'b0;
    c = 0;
    for (int i = 0; i <= int'(len); i++) begin
      usr_wdat_i = ds[i]; usr_wstrb_i = ss[i]; usr_wvalid_i = 1'b1;
      for (int k = 0; k < 16; k++) begin
        w = alt ? (c % 2 == 0) : ((k >= 4) || ($urandom_range(0, 1) == 1));
        c++;
        wready = w;
        tick();
        if (w) break;
      end
    end
    usr_wvalid_i = 1'b0; wready = 1'b0;
    repeat (b_dly) tick();
    bvalid = 1'b1; bresp = br; bid = bad_bid ? 4'(MST_ID + 1) : 4'(MST_ID);
    tick();
    bvalid = 1'b0;
  endtask

  task automatic abort_write();
    logic [63:0] d0, d1;
    logic [7:0]  s0;
    d0 = {$urandom, $urandom}; d1 = {$urandom, $urandom}; s0 = 8'hA5;
    exp_aw.push_back('{32'h3000, 8'd3});
    exp_w.push_back('{d0, s0, 1'b0});
    issue_req(1'b1, 32'h3000, 8'd3);
    for (int k = 0; k < 20 && !awvalid; k++) tick();
    awready = 1'b1;
    tick();
    awready = 1'b0;
    usr_wvalid_i = 1'b1; usr_wdat_i = d0; usr_wstrb_i = s0; wready = 1'b1;
    tick();
    wready = 1'b0; usr_wdat_i = d1; areset = 1'b1;
    tick();
    chk("abort_awvalid", 64'(awvalid), 64'd0);
    chk("abort_wvalid", 64'(wvalid), 64'd0);
    chk("abort_arvalid", 64'(arvalid), 64'd0);
    chk("abort_bready", 64'(bready), 64'd0);
    chk("abort_done", 64'(usr_done_o), 64'd0);
    chk("abort_idle", 64'(usr_req_ready_o), 64'd1);
    areset = 1'b0; wready = 1'b1;
    tick();
    wready = 1'b0; usr_wvalid_i = 1'b0;
    repeat (3) tick();
    chk("abort_w_left", 64'(exp_w.size()), 64'd0);
  endtask

  logic [1:0] last_resp = 2'b00;

  // Monitor: pops expectations whenever the DUT presents the matching event.
  initial begin
    bit ar_wait, aw_wait;
    logic [31:0] pa_ar, pa_aw;
    logic [7:0] pl_ar, pl_aw;
    ax_t e; rd_t er; wr_t ew; logic [1:0] ed;
    ar_wait = 1'b0; aw_wait = 1'b0;
    forever begin
      @(negedge aclk);
      if (areset) begin
        ar_wait = 1'b0; aw_wait = 1'b0; last_resp = 2'b00;
      end else begin
        if (ar_wait) begin
          chk("ar_hold_valid", 64'(arvalid), 64'd1);
          chk("ar_hold_addr", 64'(araddr), 64'(pa_ar));
          chk("ar_hold_len", 64'(arlen), 64'(pl_ar));
        end
        if (aw_wait) begin
          chk("aw_hold_valid", 64'(awvalid), 64'd1);
          chk("aw_hold_addr", 64'(awaddr), 64'(pa_aw));
          chk("aw_hold_len", 64'(awlen), 64'(pl_aw));
        end
        if (arvalid) chk("ar_expected", 64'(exp_ar.size() != 0), 64'd1);
        if (awvalid) chk("aw_expected", 64'(exp_aw.size() != 0), 64'd1);
        if (arvalid && arready && exp_ar.size() != 0) begin
          e = exp_ar.pop_front();
          chk("araddr", 64'(araddr), 64'(e.addr));
          chk("arlen", 64'(arlen), 64'(e.len));
          chk("arsize", 64'(arsize), 64'd3);
          chk("arburst", 64'(arburst), 64'd1);
          chk("arcache", 64'(arcache), 64'd2);
          chk("arid", 64'(arid), 64'(MST_ID));
        end
        if (awvalid && awready && exp_aw.size() != 0) begin
          e = exp_aw.pop_front();
          chk("awaddr", 64'(awaddr), 64'(e.addr));
          chk("awlen", 64'(awlen), 64'(e.len));
          chk("awsize", 64'(awsize), 64'd3);
          chk("awburst", 64'(awburst), 64'd1);
          chk("awid", 64'(awid), 64'(MST_ID));
        end
        if (wvalid) begin
          chk("w_after_aw", 64'(exp_aw.size() == 0), 64'd1);
          chk("usr_wready_pass", 64'(usr_wready_o), 64'(wready));
        end
        if (wvalid && wready) begin
          chk("w_expected", 64'(exp_w.size() != 0), 64'd1);
          if (exp_w.size() != 0) begin
            ew = exp_w.pop_front();
            chk("wdata", wdata, ew.data);
            chk("wstrb", 64'(wstrb), 64'(ew.strb));
            chk("wlast", 64'(wlast), 64'(ew.last));
          end
        end
        if (usr_rvalid_o) begin
          chk("rready", 64'(rready), 64'd1);
          chk("rd_expected", 64'(exp_rd.size() != 0), 64'd1);
          if (exp_rd.size() != 0) begin
            er = exp_rd.pop_front();
            chk("usr_rdat", usr_rdat_o, er.data);
            chk("usr_rlast", 64'(usr_rlast_o), 64'(er.last));
          end
        end
        if (bvalid) chk("bready", 64'(bready), 64'd1);
        if (usr_done_o) begin
          chk("done_expected", 64'(exp_done.size() != 0), 64'd1);
          if (exp_done.size() != 0) begin
            ed = exp_done.pop_front();
            chk("usr_resp", 64'(usr_resp_o), 64'(ed));
            last_resp = ed;
          end
        end else begin
          chk("resp_hold", 64'(usr_resp_o), 64'(last_resp));
        end
        ar_wait = arvalid && !arready; pa_ar = araddr; pl_ar = arlen;
        aw_wait = awvalid && !awready; pa_aw = awaddr; pl_aw = awlen;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    logic [7:0]  l;
    int          nb, brid;
    areset = 1'b1;
    awready = 0; wready = 0; arready = 0;
    bid = '0; bresp = '0; buser = '0; bvalid = 0;
    rid = '0; rdata = '0; rresp = '0; rlast = 0; ruser = '0; rvalid = 0;
    usr_req_i = 0; usr_wen_i = 0; usr_addr_i = '0; usr_len_i = '0;
    usr_wdat_i = '0; usr_wstrb_i = '0; usr_wvalid_i = 0;
    repeat (3) tick();
    chk("rst_arvalid", 64'(arvalid), 64'd0);
    chk("rst_awvalid", 64'(awvalid), 64'd0);
    chk("rst_wvalid", 64'(wvalid), 64'd0);
    chk("rst_rready", 64'(rready), 64'd0);
    chk("rst_bready", 64'(bready), 64'd0);
    chk("rst_usr_wready", 64'(usr_wready_o), 64'd0);
    chk("rst_usr_rvalid", 64'(usr_rvalid_o), 64'd0);
    chk("rst_done", 64'(usr_done_o), 64'd0);
    chk("rst_resp", 64'(usr_resp_o), 64'd0);
    areset = 1'b0;
    chk("ready_after_reset", 64'(usr_req_ready_o), 64'd1);

    read_txn(32'h0000_1000, 8'd3, 4, 0, -1, -1, 2'b00, 1'b0);
    write_txn(32'h0000_2000, 8'd1, 0, 1'b1, 1, 2'b00, 1'b0);
    read_txn(32'h0000_0FF0, 8'd3, 4, 0, -1, -1, 2'b00, 1'b0);
    write_txn(32'h0000_5FF0, 8'd3, 0, 1'b0, 0, 2'b00, 1'b0);
    read_txn(32'h0000_0FE0, 8'd3, 4, 1, -1, -1, 2'b00, 1'b0);
    read_txn(32'h0000_1100, 8'd3, 2, 0, -1, -1, 2'b00, 1'b0);
    read_txn(32'h0000_1200, 8'd3, 4, 1, -1, 1, 2'b10, 1'b0);
    read_txn(32'h0000_1280, 8'd3, 4, 0, 2, -1, 2'b00, 1'b0);
    write_txn(32'h0000_2100, 8'd2, 1, 1'b0, 2, 2'b00, 1'b1);
    write_txn(32'h0000_2200, 8'd0, 0, 1'b0, 0, 2'b01, 1'b0);
    read_txn(32'h0000_1300, 8'd2, 3, 5, -1, -1, 2'b00, 1'b0);
    write_txn(32'h0000_2300, 8'd1, 5, 1'b0, 1, 2'b00, 1'b0);
    abort_write();
    read_txn(32'h0000_1400, 8'd3, 4, 1, -1, -1, 2'b00, 1'b0);

    for (int t = 0; t < 40; t++) begin
      l = 8'($urandom_range(0, 7));
      a = $urandom;
      if ($urandom_range(0, 3) == 0) a[11:0] = 12'hFC0 + 12'($urandom_range(0, 63));
      else                           a[11:0] = 12'($urandom_range(0, 3000));
      if ($urandom_range(0, 1) == 1) begin
        nb   = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, int'(l) + 2)) : int'(l) + 1;
        brid = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, nb - 1)) : -1;
        read_txn(a, l, nb, int'($urandom_range(0, 3)), brid, -1, 2'b00, 1'b1);
      end else begin
        write_txn(a, l, int'($urandom_range(0, 3)), 1'b0, int'($urandom_range(0, 3)),
                  2'($urandom_range(0, 3)), ($urandom_range(0, 7) == 0));
      end
    end

    repeat (5) tick();
    chk("left_ar", 64'(exp_ar.size()), 64'd0);
    chk("left_aw", 64'(exp_aw.size()), 64'd0);
    chk("left_w", 64'(exp_w.size()), 64'd0);
    chk("left_rd", 64'(exp_rd.size()), 64'd0);
    chk("left_done", 64'(exp_done.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
